// File: rtl/stopwatch_display_scan_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_display_scan_pkg
// Shared constants for the stopwatch 4-digit multiplexed 7-segment scanner:
//   - active-low segment encodings {g,f,e,d,c,b,a} for BCD 0..9, dash, blank
//   - digit-slot indices (also the scan order, slot 0 first)
//   - default scan prescaler settings
//   - helper mapping a slot index to its active-low anode enable pattern
// -----------------------------------------------------------------------------
package stopwatch_display_scan_pkg;

    localparam int SCAN_DIV_DEFAULT = 50000;
    localparam int CNT_W_DEFAULT    = 16;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] SLOT_MS0 = 2'd0;
    localparam logic [1:0] SLOT_S0  = 2'd1;
    localparam logic [1:0] SLOT_S1  = 2'd2;
    localparam logic [1:0] SLOT_M0  = 2'd3;

    // Active-low one-cold anode pattern for a digit slot.
    function automatic logic [3:0] slot_to_an(input logic [1:0] slot);
        return ~(4'b0001 << slot);
    endfunction

endpackage

// File: rtl/stopwatch_display_scan_bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD to active-low 7-segment decoder.
// Ports:
//   i_bcd   [3:0] BCD digit; 10..15 decode to a dash
//   i_blank       1 = force all segments off (SEG_BLANK)
//   o_seg   [6:0] active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_seg7
    import stopwatch_display_scan_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    logic [6:0] w_digit_seg;

    // Digit lookup; every non-BCD code shows a dash.
    always_comb begin
        w_digit_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    w_digit_seg = SEG_0;
            4'd1:    w_digit_seg = SEG_1;
            4'd2:    w_digit_seg = SEG_2;
            4'd3:    w_digit_seg = SEG_3;
            4'd4:    w_digit_seg = SEG_4;
            4'd5:    w_digit_seg = SEG_5;
            4'd6:    w_digit_seg = SEG_6;
            4'd7:    w_digit_seg = SEG_7;
            4'd8:    w_digit_seg = SEG_8;
            4'd9:    w_digit_seg = SEG_9;
            default: w_digit_seg = SEG_DASH;
        endcase
    end

    // Blank override.
    always_comb begin
        o_seg = w_digit_seg;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            o_seg = w_digit_seg;
        end
    end

endmodule

// File: rtl/stopwatch_display_scan.sv
// -----------------------------------------------------------------------------
// stopwatch_display_scan
// Drives a 4-digit multiplexed 7-segment display from the stopwatch digits.
// The four input digits are captured into shadow registers once per scan
// frame (at the idx 3->0 slot change) so a frame never mixes old and new
// digits; hold freezes the shadow for lap display. Outputs are registered
// from the current slot index and the shadow digits.
//
// Optional build macro: STOPWATCH_LZ_BLANK_EN enables leading-zero blanking
// of the minutes and tens-of-seconds slots.
//
// Parameters:
//   SCAN_DIV   clk cycles per digit slot (2..2^CNT_W)
//   CNT_W      prescaler width
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   min0, sec1, sec0, milSec0 [3:0]  BCD digits from the stopwatch
//   hold        1 = keep current snapshot at frame boundaries
//   an    [3:0] active-low digit enables (an[0]=milSec0 .. an[3]=min0)
//   seg   [6:0] active-low segments {g,f,e,d,c,b,a}
//   dp          active-low decimal point (lit in the sec0 slot)
//   frame_tick  one-cycle pulse after each snapshot slot change
// -----------------------------------------------------------------------------
module stopwatch_display_scan
    import stopwatch_display_scan_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic [3:0] milSec0,
    input  logic       hold,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    logic [CNT_W-1:0] r_presc;
    logic [1:0]       r_idx;
    logic [3:0]       r_sh_m0;
    logic [3:0]       r_sh_s1;
    logic [3:0]       r_sh_s0;
    logic [3:0]       r_sh_ms0;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_frame_tick;

    logic             w_tc;
    logic             w_frame_edge;
    logic [3:0]       w_digit;
    logic             w_blank;
    logic [6:0]       w_seg;

    assign w_tc         = (r_presc == CNT_W'(SCAN_DIV - 1));
    assign w_frame_edge = w_tc && (r_idx == SLOT_M0);

    // Prescaler and slot index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else if (w_tc) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + CNT_W'(1);
            r_idx   <= r_idx;
        end
    end

    // Shadow digits: loaded only at the frame boundary and only when not held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sh_m0  <= 4'd0;
            r_sh_s1  <= 4'd0;
            r_sh_s0  <= 4'd0;
            r_sh_ms0 <= 4'd0;
        end else if (w_frame_edge && !hold) begin
            r_sh_m0  <= min0;
            r_sh_s1  <= sec1;
            r_sh_s0  <= sec0;
            r_sh_ms0 <= milSec0;
        end else begin
            r_sh_m0  <= r_sh_m0;
            r_sh_s1  <= r_sh_s1;
            r_sh_s0  <= r_sh_s0;
            r_sh_ms0 <= r_sh_ms0;
        end
    end

    // Select the shadow digit for the current slot.
    always_comb begin
        w_digit = r_sh_ms0;
        case (r_idx)
            SLOT_MS0: w_digit = r_sh_ms0;
            SLOT_S0:  w_digit = r_sh_s0;
            SLOT_S1:  w_digit = r_sh_s1;
            SLOT_M0:  w_digit = r_sh_m0;
            default:  w_digit = r_sh_ms0;
        endcase
    end

`ifdef STOPWATCH_LZ_BLANK_EN
    // Leading-zero blanking: minutes blank when 0, tens-of-seconds blank only
    // when the minutes are blank too. Zero tests never match a dash code.
    always_comb begin
        w_blank = 1'b0;
        if (r_idx == SLOT_M0) begin
            w_blank = (r_sh_m0 == 4'd0);
        end else if (r_idx == SLOT_S1) begin
            w_blank = (r_sh_m0 == 4'd0) && (r_sh_s1 == 4'd0);
        end else begin
            w_blank = 1'b0;
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    bcd_to_seg7 u_bcd_to_seg7 (
        .i_bcd   (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    // Registered display outputs, one cycle behind the slot index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_an         <= 4'hF;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= slot_to_an(r_idx);
            r_seg        <= w_seg;
            r_dp         <= (r_idx == SLOT_S0) ? 1'b0 : 1'b1;
            r_frame_tick <= w_frame_edge;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_display_scan
// Directed bench for stopwatch_display_scan with SCAN_DIV=4 (16-cycle frames).
// A frame-level reference (cycle count since reset, shadow digits captured at
// every 16th cycle) pushes the expected {an,seg,dp,frame_tick} per clock into
// a queue; the value is popped and compared 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_display_scan;

    localparam int SD = 4;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] min0, sec1, sec0, milSec0;
    logic       hold;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;
    int n = 0;
    int ft_seen = 0;
    logic [3:0] m_sh [4];
    logic [12:0] exp_q [$];

    stopwatch_display_scan #(.SCAN_DIV(SD), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .min0       (min0),
        .sec1       (sec1),
        .sec0       (sec0),
        .milSec0    (milSec0),
        .hold       (hold),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: compute expectation at the edge, compare just after it.
    task automatic step();
        int slot;
        logic blank;
        logic [6:0] s;
        logic [12:0] e;
        @(posedge clk);
        if (!reset) begin
            e = {4'hF, 7'h7F, 1'b1, 1'b0};
            n = 0;
            for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
        end else begin
            n++;
            slot = ((n - 1) / SD) % 4;
            blank = 1'b0;
`ifdef STOPWATCH_LZ_BLANK_EN
            if (slot == 3) blank = (m_sh[3] == 4'd0);
            if (slot == 2) blank = (m_sh[3] == 4'd0) && (m_sh[2] == 4'd0);
`endif
            s = blank ? 7'h7F : ref_seg(m_sh[slot]);
            e = {~(4'b0001 << slot), s, (slot == 1) ? 1'b0 : 1'b1, (n % FRAME == 0) ? 1'b1 : 1'b0};
            if ((n % FRAME == 0) && !hold) begin
                m_sh[0] = milSec0;
                m_sh[1] = sec0;
                m_sh[2] = sec1;
                m_sh[3] = min0;
            end
        end
        exp_q.push_back(e);
        #1;
        if (frame_tick === 1'b1) ft_seen++;
        check($sformatf("cyc%0d_an_seg_dp_ft", n), {19'd0, an, seg, dp, frame_tick}, {19'd0, exp_q.pop_front()});
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic set_in(input logic [3:0] m, input logic [3:0] s1, input logic [3:0] s0, input logic [3:0] ms);
        min0 = m; sec1 = s1; sec0 = s0; milSec0 = ms;
    endtask

    initial begin
        reset = 1'b0;
        hold  = 1'b0;
        set_in(4'd0, 4'd0, 4'd0, 4'd0);
        #2;

        // Reset held for three edges.
        run(3);
        check("reset_an", {28'd0, an}, 32'hF);
        check("reset_seg", {25'd0, seg}, 32'h7F);

        // Release; frame 0 shows zeros, frame 1 shows 1,2,3,4.
        reset = 1'b1;
        set_in(4'd1, 4'd2, 4'd3, 4'd4);
        ft_seen = 0;
        run(FRAME + 1);
        check("f1_ms0_slot", {21'd0, an, seg}, {21'd0, 4'hE, 7'h19});
        run(2 * FRAME - 1);
        check("frame_tick_count", ft_seen, 3);

        // Hold mid-frame with new inputs, then release hold mid-frame.
        hold = 1'b1;
        set_in(4'd9, 4'd5, 4'd9, 4'd9);
        run(40);
        hold = 1'b0;
        run(40);

        // Leading-zero cases and an invalid sub-second digit.
        set_in(4'd0, 4'd0, 4'd7, 4'd0);
        run(2 * FRAME);
        set_in(4'd0, 4'd3, 4'd7, 4'd0);
        run(2 * FRAME);
        set_in(4'd0, 4'd0, 4'd7, 4'd12);
        run(2 * FRAME);

        // Reset mid-frame while idx==2, with non-zero inputs still applied.
        set_in(4'd1, 4'd2, 4'd3, 4'd4);
        while ((n % FRAME) != (2 * SD + 1)) step();
        reset = 1'b0;
        step();
        check("midreset_an", {28'd0, an}, 32'hF);
        reset = 1'b1;
        run(FRAME + 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_display_scan.md
Name: stopwatch_display_scan

Overview:
- Downstream consumer of the stopwatch digit outputs: takes the four BCD digits min0, sec1, sec0, milSec0 and drives a 4-digit multiplexed 7-segment display.
- Snapshots the digits once per scan frame to prevent tearing, and supports a hold (lap) freeze.
- Decodes BCD to active-low segments and applies leading-zero blanking.
- The decimal point separates seconds from the sub-second digit.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (1 kHz digit rate at 50 MHz); legal range 2..2^CNT_W.
- CNT_W, 16, prescaler counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- min0  input  4  BCD minutes digit from stopwatch.
- sec1  input  4  BCD tens-of-seconds digit (0..5 nominal).
- sec0  input  4  BCD seconds digit.
- milSec0  input  4  BCD sub-second digit.
- hold  input  1  1 = freeze snapshot (lap display); the stopwatch keeps running.
- an  output  4  active-low digit enables; an[0]=milSec0, an[1]=sec0, an[2]=sec1, an[3]=min0.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.
- frame_tick  output  1  one-cycle pulse when the snapshot slot (idx 3->0) occurs.

Behaviour:
- Reset (reset==0 at a rising edge):
  - Prescaler = 0, idx = 0, shadow digits = 0.
  - an = 4'hF, seg = 7'h7F, dp = 1, frame_tick = 0.
  - Reset takes priority over all other activity, including mid-frame and during hold.
- Prescaler counts 0..SCAN_DIV-1 and wraps. Terminal count (TC) = prescaler==SCAN_DIV-1.
- On TC: idx <= idx+1 (mod 4; 3 wraps to 0).
- Snapshot on a TC edge with idx==3 (the frame boundary):
  - frame_tick = 1 on the following cycle.
  - If hold==0, the shadow registers load all four inputs on that edge.
  - If hold==1, the shadow keeps its value.
  - Inputs are never used directly by the decode.
- Outputs are registered from the current idx and the shadow digits: one cycle of latency after each idx change. Exactly one an bit is low at any time after the first post-reset cycle.
- BCD decode (seg hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any value 10..15 shows a dash (3F); a dash is never blanked.
- dp = 0 only while idx==1 (sec0 slot); otherwise 1.
- Leading-zero blanking (macro present):
  - min0 slot shows blank (seg 7F, an still driven) when shadow min0==0.
  - sec1 slot is blank when shadow min0==0 and shadow sec1==0.
  - sec0 and milSec0 are never blanked.
- Slot order and period: one frame = 4*SCAN_DIV cycles; frame_tick period equals the frame length.
- hold toggled mid-frame: takes effect only at the next frame boundary.

Optional Feature:
- Macro: STOPWATCH_LZ_BLANK_EN.
- Defined: leading-zero blanking as specified above.
- Undefined: all four slots always show the decoded digit (0 shows 40); no other change.

Decomposition:
- Shared package/header holds:
  - the segment encoding constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK);
  - the digit-slot index constants (SLOT_MS0, SLOT_S0, SLOT_S1, SLOT_M0);
  - the default SCAN_DIV.
- One natural sub-module: bcd_to_seg7, a combinational decoder with a blank input that returns SEG_BLANK when asserted.
- The top level holds the prescaler, idx, shadow registers and output registers.

Test Plan (SCAN_DIV=4):
- Reset held low 3 cycles, then released -> an=F, seg=7F, dp=1 during reset; first frame shows 0.0.0.0 pattern with LZ blanking off (seg=40 in each slot).
- Inputs min0=1, sec1=2, sec0=3, milSec0=4 applied before a frame boundary -> next frame: an=E seg=19; an=D seg=30 dp=0; an=B seg=24; an=7 seg=79. Each slot lasts 4 cycles; frame_tick every 16 cycles.
- hold=1, then inputs changed to 9,5,9,9 -> display stays 1,2,3,4 for several frames; hold=0 -> new values appear only from the frame after the next boundary.
- STOPWATCH_LZ_BLANK_EN defined, min0=0, sec1=0, sec0=7, milSec0=0 -> an=7 and an=B slots seg=7F; an=D seg=78 dp=0; an=E seg=40. With min0=0, sec1=3 -> sec1 slot seg=30.
- milSec0=12 (invalid) -> that slot seg=3F, still shown with blanking enabled.
- reset pulsed low mid-frame at idx=2 -> next cycle an=F, seg=7F, idx restarts at 0, shadow cleared.
